// File: rtl/secure_rx_monitor.sv
// Receive-side monitor for the secure status/strobe/data session handshake.
// Captures the strobed word and secure flag, and keeps sticky protocol-violation flags.
module secure_rx_monitor #(
    parameter int                DATA_W      = 32,
    parameter int                STROBE_GAP  = 5,
    parameter int                TIMEOUT     = 31,
    parameter logic [DATA_W-1:0] EXPECT_DATA = 'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              status_in,
    input  logic              strobe_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              secure_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_secure,
    output logic              rx_valid,
    output logic              busy,
    output logic [7:0]        gap_cnt,
    output logic              err_gap,
    output logic              err_width,
    output logic              err_timeout,
    output logic              err_data
);

    // state | meaning
    // IDLE  | no session; waiting for status high
    // HOLD  | source in reset/busy; waiting for status fall
    // WAIT  | capture window open; counting cycles toward the strobe
    // CHECK | word captured; rx_valid high; strobe must already be gone
    // DONE  | session complete; any strobe here is a width error
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] GAP_C     = 8'(STROBE_GAP);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              status_q, status_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_secure_q, rx_secure_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              err_gap_q, err_gap_d;
    logic              err_width_q, err_width_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_data_q, err_data_d;

    logic              fall;
    logic [7:0]        cnt_inc;

    assign fall    = status_q & ~status_in;
    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (status_in) state_d = HOLD;
            end
            HOLD: begin
                if (fall) state_d = WAIT;
            end
            WAIT: begin
                // abort beats capture, capture beats timeout
                if (status_in)                 state_d = HOLD;
                else if (strobe_in)            state_d = CHECK;
                else if (cnt_inc == TIMEOUT_C) state_d = IDLE;
            end
            CHECK: begin
                state_d = DONE;
            end
            DONE: begin
                if (status_in) state_d = HOLD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        status_d      = status_in;
        cnt_d         = cnt_q;
        rx_data_d     = rx_data_q;
        rx_secure_d   = rx_secure_q;
        rx_valid_d    = 1'b0;
        gap_cnt_d     = gap_cnt_q;
        err_gap_d     = err_gap_q;
        err_width_d   = err_width_q;
        err_timeout_d = err_timeout_q;
        err_data_d    = err_data_q;
        busy_d        = (state_d == HOLD) || (state_d == WAIT) || (state_d == CHECK);

        case (state_q)
            HOLD: begin
                if (fall) begin
                    cnt_d       = 8'd0;
                    rx_secure_d = secure_in;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (!status_in) begin
                    if (strobe_in) begin
                        rx_data_d  = data_in;
                        gap_cnt_d  = cnt_inc;
                        rx_valid_d = 1'b1;
                        err_gap_d  = err_gap_q | (cnt_inc != GAP_C);
                        err_data_d = err_data_q | (data_in != EXPECT_DATA);
                    end else if (cnt_inc == TIMEOUT_C) begin
                        err_timeout_d = 1'b1;
                    end
                end
            end
            CHECK, DONE: begin
                if (strobe_in) err_width_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q      <= 1'b0;
            cnt_q         <= 8'd0;
            rx_data_q     <= '0;
            rx_secure_q   <= 1'b0;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            gap_cnt_q     <= 8'd0;
            err_gap_q     <= 1'b0;
            err_width_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_data_q    <= 1'b0;
        end else begin
            status_q      <= status_d;
            cnt_q         <= cnt_d;
            rx_data_q     <= rx_data_d;
            rx_secure_q   <= rx_secure_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            gap_cnt_q     <= gap_cnt_d;
            err_gap_q     <= err_gap_d;
            err_width_q   <= err_width_d;
            err_timeout_q <= err_timeout_d;
            err_data_q    <= err_data_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_secure   = rx_secure_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = busy_q;
    assign gap_cnt     = gap_cnt_q;
    assign err_gap     = err_gap_q;
    assign err_width   = err_width_q;
    assign err_timeout = err_timeout_q;
    assign err_data    = err_data_q;

endmodule

// File: tb/tb_secure_rx_monitor.sv
// Bench for secure_rx_monitor: cycle vectors, directed corner sequences and
// randomized sessions checked against a session-level reference model.
module tb_secure_rx_monitor;

    localparam int          DW  = 32;
    localparam int          GAP = 5;
    localparam int          TO  = 31;
    localparam logic [31:0] EXP = 32'hFF;

    logic          clk = 1'b0;
    logic          rst, status_in, strobe_in, secure_in;
    logic [DW-1:0] data_in;
    logic [DW-1:0] rx_data;
    logic          rx_secure, rx_valid, busy;
    logic [7:0]    gap_cnt;
    logic          err_gap, err_width, err_timeout, err_data;

    int nchk = 0;
    int nerr = 0;
    int vcnt = 0;

    secure_rx_monitor #(
        .DATA_W(DW), .STROBE_GAP(GAP), .TIMEOUT(TO), .EXPECT_DATA(EXP)
    ) dut (
        .clk(clk), .rst(rst), .status_in(status_in), .strobe_in(strobe_in),
        .data_in(data_in), .secure_in(secure_in),
        .rx_data(rx_data), .rx_secure(rx_secure), .rx_valid(rx_valid), .busy(busy),
        .gap_cnt(gap_cnt), .err_gap(err_gap), .err_width(err_width),
        .err_timeout(err_timeout), .err_data(err_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        rst, st, sb, sec;
        logic [31:0] data;
        logic        ev, eb, es;
        logic [7:0]  eg;
        logic [3:0]  ee;
        logic [31:0] ed;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic st, input logic sb, input logic sec,
                       input logic [31:0] d, input logic ev, input logic eb, input logic es,
                       input logic [7:0] eg, input logic [3:0] ee, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.st = st; v.sb = sb; v.sec = sec; v.data = d;
        v.ev = ev; v.eb = eb; v.es = es; v.eg = eg; v.ee = ee; v.ed = ed;
        vt.push_back(v);
    endtask

    function automatic logic [46:0] obs();
        return {rx_valid, busy, rx_secure, gap_cnt,
                err_gap, err_width, err_timeout, err_data, rx_data};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rx_valid) vcnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1; status_in = 1'b0; strobe_in = 1'b0; secure_in = 1'b0; data_in = '0;
        tick();
        rst = 1'b0;
        vcnt = 0;
    endtask

    // One source session: status high, fall with sec, strobe at cycle gap
    // (0 = never) for width cycles, optional status re-rise at cycle abort_at.
    task automatic drive_session(input logic sec, input int gap, input int width,
                                 input logic [31:0] dstb, input int abort_at,
                                 output int pulses);
        int last;
        vcnt = 0;
        status_in = 1'b1; strobe_in = 1'b0; secure_in = ~sec; data_in = $urandom;
        tick();
        status_in = 1'b0; secure_in = sec;
        tick();
        secure_in = ~sec;
        last = (gap + width > TO) ? gap + width : TO;
        for (int k = 1; k <= last; k++) begin
            strobe_in = (gap != 0) && (k >= gap) && (k < gap + width);
            data_in   = (k == gap) ? dstb : $urandom;
            if (k == abort_at) begin
                status_in = 1'b1;
                tick();
                strobe_in = 1'b0;
                pulses = vcnt;
                return;
            end
            tick();
        end
        strobe_in = 1'b0;
        tick();
        tick();
        pulses = vcnt;
    endtask

    logic [31:0] m_data;
    logic        m_sec;
    logic [7:0]  m_gap;
    logic [3:0]  m_err;

    initial begin
        int pulses;
        rst = 1'b1; status_in = 1'b0; strobe_in = 1'b0; secure_in = 1'b0; data_in = '0;

        add(1, 0, 0, 0, 32'h0,  0, 0, 0, 8'd0, 4'b0000, 32'h0);
        add(0, 0, 0, 0, 32'h0,  0, 0, 0, 8'd0, 4'b0000, 32'h0);
        for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 32'h0, 0, 1, 0, 8'd0, 4'b0000, 32'h0);
        add(0, 0, 0, 0, 32'h0,  0, 1, 0, 8'd0, 4'b0000, 32'h0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 32'h0, 0, 1, 0, 8'd0, 4'b0000, 32'h0);
        add(0, 0, 1, 0, 32'hFF, 1, 1, 0, 8'd5, 4'b0000, 32'hFF);
        add(0, 0, 0, 0, 32'h0,  0, 0, 0, 8'd5, 4'b0000, 32'hFF);
        add(0, 0, 0, 0, 32'h0,  0, 0, 0, 8'd5, 4'b0000, 32'hFF);
        add(0, 1, 0, 0, 32'h0,  0, 1, 0, 8'd5, 4'b0000, 32'hFF);
        add(0, 1, 0, 0, 32'h0,  0, 1, 0, 8'd5, 4'b0000, 32'hFF);
        add(0, 0, 0, 1, 32'h0,  0, 1, 1, 8'd5, 4'b0000, 32'hFF);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 32'h0, 0, 1, 1, 8'd5, 4'b0000, 32'hFF);
        add(0, 0, 1, 0, 32'hFF, 1, 1, 1, 8'd5, 4'b0000, 32'hFF);
        add(0, 0, 0, 0, 32'h0,  0, 0, 1, 8'd5, 4'b0000, 32'hFF);
        add(0, 1, 0, 0, 32'h0,  0, 1, 1, 8'd5, 4'b0000, 32'hFF);
        add(0, 0, 0, 0, 32'h0,  0, 1, 0, 8'd5, 4'b0000, 32'hFF);
        add(0, 0, 0, 0, 32'h0,  0, 1, 0, 8'd5, 4'b0000, 32'hFF);
        add(0, 0, 0, 0, 32'h0,  0, 1, 0, 8'd5, 4'b0000, 32'hFF);
        add(0, 0, 1, 0, 32'h0,  1, 1, 0, 8'd3, 4'b1001, 32'h0);
        add(0, 0, 0, 0, 32'h0,  0, 0, 0, 8'd3, 4'b1001, 32'h0);

        foreach (vt[i]) begin
            rst = vt[i].rst; status_in = vt[i].st; strobe_in = vt[i].sb;
            secure_in = vt[i].sec; data_in = vt[i].data;
            tick();
            chk($sformatf("vec[%0d]", i), 64'(obs()),
                64'({vt[i].ev, vt[i].eb, vt[i].es, vt[i].eg, vt[i].ee, vt[i].ed}));
        end

        // sticky flags survive a clean session, then clear on reset
        drive_session(1'b0, 5, 1, 32'hFF, 0, pulses);
        chk("persist_pulses", 64'(pulses), 64'd1);
        chk("persist_state", 64'(obs()), 64'({1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 32'hFF}));
        do_reset();
        chk("reset_clears", 64'(obs()), 64'd0);

        drive_session(1'b0, 5, 2, 32'hFF, 0, pulses);
        chk("stretch_pulses", 64'(pulses), 64'd1);
        chk("stretch_state", 64'(obs()), 64'({1'b0, 1'b0, 1'b0, 8'd5, 4'b0100, 32'hFF}));

        // timeout: no strobe after the fall
        do_reset();
        status_in = 1'b1; tick();
        status_in = 1'b0; tick();
        for (int k = 1; k <= 30; k++) tick();
        chk("to_before", 64'({busy, err_timeout}), 64'b10);
        tick();
        chk("to_after", 64'({busy, err_timeout, rx_valid}), 64'b010);
        chk("to_pulses", 64'(vcnt), 64'd0);

        // abort at gap 2, then a normal secure session
        do_reset();
        drive_session(1'b0, 5, 1, 32'hFF, 2, pulses);
        chk("abort_pulses", 64'(pulses), 64'd0);
        chk("abort_state", 64'(obs()), 64'({1'b0, 1'b1, 1'b0, 8'd0, 4'b0000, 32'h0}));
        drive_session(1'b1, 5, 1, 32'hFF, 0, pulses);
        chk("post_abort_pulses", 64'(pulses), 64'd1);
        chk("post_abort_state", 64'(obs()), 64'({1'b0, 1'b0, 1'b1, 8'd5, 4'b0000, 32'hFF}));

        // reset in WAIT at gap 3, with a strobe presented on the same edge
        status_in = 1'b1; tick();
        status_in = 1'b0; secure_in = 1'b1; tick();
        tick(); tick();
        vcnt = 0;
        rst = 1'b1; strobe_in = 1'b1; data_in = 32'hFF; tick();
        rst = 1'b0; strobe_in = 1'b0; tick();
        chk("rst_wait_state", 64'(obs()), 64'd0);
        chk("rst_wait_pulses", 64'(vcnt), 64'd0);

        // status rise and strobe on the same WAIT cycle: abort wins
        do_reset();
        drive_session(1'b0, 5, 1, 32'hFF, 5, pulses);
        chk("abort_vs_strobe", 64'({pulses[1:0], obs()}), 64'({2'd0, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0000, 32'h0}));

        // strobe on the timeout cycle: capture wins
        do_reset();
        drive_session(1'b0, TO, 1, 32'hFF, 0, pulses);
        chk("strobe_vs_to", 64'({pulses[1:0], obs()}), 64'({2'd1, 1'b0, 1'b0, 1'b0, 8'd31, 4'b1000, 32'hFF}));

        // randomized sessions against a session-level model
        do_reset();
        m_data = '0; m_sec = 1'b0; m_gap = '0; m_err = '0;
        for (int s = 0; s < 40; s++) begin
            logic        sec, good, valid_gap;
            int          r, gap, width, ab, exp_p;
            logic [31:0] d;
            sec   = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 9);
            if (r < 5)       gap = GAP;
            else if (r == 5) gap = 0;
            else             gap = $urandom_range(1, 33);
            width = $urandom_range(1, 2);
            good  = ($urandom_range(0, 3) != 0);
            d     = good ? EXP : $urandom;
            if (!good && d == EXP) d = 32'h1FF;
            valid_gap = (gap >= 1) && (gap <= TO);
            ab = 0;
            if ($urandom_range(0, 5) == 0) ab = $urandom_range(1, valid_gap ? gap : TO);

            drive_session(sec, gap, width, d, ab, pulses);

            m_sec = sec;
            exp_p = 0;
            if (ab == 0) begin
                if (valid_gap) begin
                    exp_p  = 1;
                    m_data = d;
                    m_gap  = 8'(gap);
                    if (gap != GAP) m_err[3] = 1'b1;
                    if (width > 1)  m_err[2] = 1'b1;
                    if (d != EXP)   m_err[0] = 1'b1;
                end else begin
                    m_err[1] = 1'b1;
                end
            end
            chk($sformatf("rand[%0d] pulses", s), 64'(pulses), 64'(exp_p));
            chk($sformatf("rand[%0d] state", s), 64'(obs()),
                64'({1'b0, (ab != 0), m_sec, m_gap, m_err, m_data}));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/secure_rx_monitor.md
# secure_rx_monitor

Receive-side endpoint for the secure status/strobe/data handshake driven by the dual-reset secure data source. It tracks the source's session:

- status high during reset;
- status falls to open the capture window;
- a one-cycle strobe presents the data word.

It latches the word and the secure flag, and flags protocol violations: wrong strobe gap, stretched strobe, missing strobe and unexpected data. It sits on the consumer side of that interface, in the same clock domain as the source.

## Interface
Parameters:
- DATA_W, 32, data word width
- STROBE_GAP, 5, required cycles from status fall to strobe
- TIMEOUT, 31, max cycles in WAIT before timeout (must be > STROBE_GAP, < 256)
- EXPECT_DATA, 32'hFF, value data_in must carry at strobe

Ports:
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- status_in  in  1  source busy/reset status
- strobe_in  in  1  source data strobe
- data_in  in  DATA_W  source data word
- secure_in  in  1  source secure flag (source's secure_out)
- rx_data  out  DATA_W  captured word
- rx_secure  out  1  secure flag latched at status fall
- rx_valid  out  1  one-cycle pulse: rx_data/rx_secure/gap_cnt updated
- busy  out  1  high in HOLD, WAIT, CHECK
- gap_cnt  out  8  measured fall-to-strobe gap of last capture
- err_gap, err_width, err_timeout, err_data  out  1 each  sticky error flags

## Operation
Registers:
- status_q: registered status_in.
- fall: combinational, status_q & ~status_in.
- cnt: 8-bit counter.

States: IDLE, HOLD, WAIT, CHECK, DONE.

- IDLE: status_in=1 -> HOLD. Nothing else.
- HOLD: on fall, perform the actions below, then -> WAIT.
  - cnt<=0.
  - rx_secure<=secure_in.
- WAIT: each cycle cnt<=cnt+1. Priority order:
  1. status_in=1 -> HOLD. Aborted session; no capture, flags unchanged.
  2. strobe_in=1 -> CHECK. On this transition:
     - rx_data<=data_in;
     - gap_cnt<=cnt+1;
     - err_gap<=err_gap | (cnt+1 != STROBE_GAP);
     - err_data<=err_data | (data_in != EXPECT_DATA).
  3. cnt+1 == TIMEOUT -> err_timeout<=1, then -> IDLE.
- CHECK: rx_valid=1 this cycle. If strobe_in still 1, err_width<=1. Then -> DONE.
- DONE: wait for status_in=1 -> HOLD, which starts a new session. A strobe seen in DONE sets err_width.
- Error flags are sticky; they clear only on rst.
- Gap measurement: the first WAIT cycle after fall counts as 1. The source's strobe 5 edges after its status fall gives gap_cnt=5.
- secure_in is sampled only at the fall. Changes afterwards are ignored until the next session.

## Timing
- Reset (rst=1 at posedge):
  - state=IDLE;
  - status_q=0;
  - cnt=0;
  - rx_data=0, rx_secure=0, rx_valid=0, gap_cnt=0;
  - busy=0;
  - all err_* = 0.
- rst has priority over every event. Reset mid-WAIT/CHECK discards the session with no rx_valid.
- Latency: strobe sampled at edge N -> rx_data valid after edge N; rx_valid high for cycle N+1 only.
- Since status_q resets to 0, status_in low immediately after reset is not a fall. The first session requires status_in high (IDLE->HOLD) first.
- Same-cycle status_in rise and strobe_in in WAIT: abort wins; no capture.
- Same-cycle strobe and timeout in WAIT: capture wins; no timeout.
- busy is a registered decode of state.
- rx_valid is registered and never asserts twice per session.

## Test plan
- Nominal non-secure: status 1 for 10 cycles, falls with secure_in=0, strobe 1 cycle at gap 5, data_in=32'hFF -> rx_valid one cycle later, rx_data=32'hFF, rx_secure=0, gap_cnt=5, all err_*=0.
- Secure session: secure_in=1 at fall, data_in=32'h0 until strobe, 32'hFF at strobe (gap 5) -> rx_secure=1, rx_data=32'hFF, no errors.
- Gap/data violation: strobe at gap 3 with data_in=32'h0 -> gap_cnt=3, err_gap=1, err_data=1, rx_valid still pulses. Flags persist through a following clean session and clear only on rst.
- Stretched strobe: strobe held 2 cycles -> err_width=1, single rx_valid. No strobe after fall -> err_timeout=1 when cnt reaches 31, busy=0, no rx_valid.
- Abort/reset: status re-rises at gap 2 -> back to HOLD, no capture. Then a normal session captures correctly. rst asserted in WAIT at gap 3 -> all outputs 0, no rx_valid.
